// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch queue unit.
// The entry struct matches the default 8-bit PC / 16-bit instruction build.
package fetch_pkg;

  localparam int FETCH_WIDTH  = 8;
  localparam int FETCH_IWIDTH = 16;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0]  pc;
    logic [FETCH_IWIDTH-1:0] instr;
  } fetch_entry_t;

  // A counter that must hold the value DEPTH itself needs one extra code.
  function automatic int cnt_width(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// Circular-buffer FIFO with push/pop/flush and occupancy count.
// The head word is read straight out of the storage flops.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generator issuing pipelined memory requests, with an
// in-order output queue toward decode and redirect-driven squashing.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               IWIDTH   = 16,
  parameter int               STEP     = 1,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  NewPC,
  input  logic              PCSelector,
  output logic              imem_req_valid,
  output logic [WIDTH-1:0]  imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [IWIDTH-1:0] imem_resp_data,
  output logic              out_valid,
  output logic [IWIDTH-1:0] out_instr,
  output logic [WIDTH-1:0]  out_pc,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  PC,
  output logic [WIDTH-1:0]  PCPlusStep
);

  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0]        pc_q, pc_d;
  logic [CW-1:0]           drop_q, drop_d;
  logic [CW-1:0]           inflight, qcount, inflight_next;
  logic [CW:0]             credit_used;
  logic                    accept, resp_ok, pop_out;
  logic                    afifo_full, afifo_empty, ofifo_full, ofifo_empty, ofifo_push;
  logic [WIDTH-1:0]        resp_addr;
  logic [WIDTH+IWIDTH-1:0] ofifo_head;

  // Outstanding request count is exactly the address FIFO occupancy.
  sync_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_addr_fifo (
    .clock(clock), .reset(reset),
    .push(accept), .push_data(pc_q), .pop(resp_ok), .flush(1'b0),
    .head(resp_addr), .full(afifo_full), .empty(afifo_empty), .count(inflight)
  );

  sync_fifo #(.W(WIDTH + IWIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clock(clock), .reset(reset),
    .push(ofifo_push), .push_data({resp_addr, imem_resp_data}), .pop(pop_out),
    .flush(PCSelector),
    .head(ofifo_head), .full(ofifo_full), .empty(ofifo_empty), .count(qcount)
  );

  always_comb begin
    credit_used    = {1'b0, inflight} + {1'b0, qcount};
    // Gating with reset keeps the request line quiet while reset is held.
    imem_req_valid = reset & enable & ~PCSelector & (credit_used < (CW + 1)'(DEPTH));
    accept         = imem_req_valid & imem_req_ready;
    resp_ok        = imem_resp_valid & ~afifo_empty;
    ofifo_push     = resp_ok & (drop_q == '0) & ~PCSelector;
    out_valid      = ~ofifo_empty & ~PCSelector;
    pop_out        = out_valid & out_ready;
    inflight_next  = inflight + CW'(accept) - CW'(resp_ok);

    pc_d   = pc_q;
    drop_d = drop_q;
    if (PCSelector) begin
      pc_d   = NewPC;
      drop_d = inflight_next;
    end else begin
      if (accept) pc_d = pc_q + WIDTH'(STEP);
      if (resp_ok && drop_q != '0) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  assign PC            = pc_q;
  assign imem_req_addr = pc_q;
  assign PCPlusStep    = pc_q + WIDTH'(STEP);
  assign out_pc        = ofifo_head[WIDTH+IWIDTH-1:IWIDTH];
  assign out_instr     = ofifo_head[IWIDTH-1:0];

  a_resp_without_req: assert property (@(posedge clock) disable iff (!reset)
    !(imem_resp_valid && inflight == '0));
  a_addr_fifo_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(afifo_full && accept));
  a_out_fifo_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(ofifo_full && ofifo_push && !pop_out));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int         DEPTH = 4;
  localparam logic [7:0] RPC   = 8'h10;

  logic        clock, reset, enable, PCSelector;
  logic [7:0]  NewPC, imem_req_addr, out_pc, PC, PCPlusStep;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [15:0] imem_resp_data, out_instr;
  logic        out_valid, out_ready;

  fetch_queue_unit #(.WIDTH(8), .IWIDTH(16), .STEP(1), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .enable(enable), .NewPC(NewPC), .PCSelector(PCSelector),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_ready(out_ready), .PC(PC), .PCPlusStep(PCPlusStep)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] addr;
    bit         sq;
  } req_t;

  req_t         outst[$];
  fetch_entry_t outq[$];
  logic [7:0]   m_pc;
  int           checks = 0;
  int           failures = 0;
  int           resp_mode;
  int           n_acc;

  function automatic logic [15:0] instr_of(logic [7:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(bit en, bit sel, logic [7:0] npc, bit mrdy, bit ordy);
    enable = en; PCSelector = sel; NewPC = npc; imem_req_ready = mrdy; out_ready = ordy;
  endtask

  // One cycle: memory decision, mid-cycle compare, model advance, next edge.
  task automatic step();
    logic         ev_req, ev_out, acc;
    logic [7:0]   nxt;
    req_t         r;
    fetch_entry_t e;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (outst.size() > 0 && (resp_mode == 1 || (resp_mode == 2 && $urandom_range(0, 1) == 1))) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(outst[0].addr);
    end
    @(negedge clock);
    ev_req = reset && enable && !PCSelector && (outst.size() + outq.size() < DEPTH);
    ev_out = (outq.size() > 0) && !PCSelector;
    nxt    = m_pc + 8'd1;
    chk("req_valid", imem_req_valid, ev_req);
    chk("req_addr", imem_req_addr, m_pc);
    chk("pc", PC, m_pc);
    chk("pc_plus_step", PCPlusStep, nxt);
    chk("out_valid", out_valid, ev_out);
    if (ev_out) begin
      chk("out_pc", out_pc, outq[0].pc);
      chk("out_instr", out_instr, outq[0].instr);
    end
    if (imem_req_valid && imem_req_ready) n_acc++;
    acc = ev_req && imem_req_ready;
    if (reset) begin
      if (ev_out && out_ready) void'(outq.pop_front());
      if (imem_resp_valid) begin
        r = outst.pop_front();
        if (!r.sq && !PCSelector) begin
          e.pc    = r.addr;
          e.instr = imem_resp_data;
          outq.push_back(e);
        end
      end
      if (PCSelector) begin
        outq.delete();
        foreach (outst[i]) outst[i].sq = 1'b1;
        m_pc = NewPC;
      end
      if (acc) begin
        r.addr = m_pc;
        r.sq   = 1'b0;
        outst.push_back(r);
        m_pc = nxt;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    resp_mode = 1;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    run(8);
  endtask

  initial begin
    reset = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    resp_mode = 1;
    n_acc = 0;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    #12;
    chk("rst_pc", PC, RPC);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_pc_plus", PCPlusStep, 8'h11);
    @(posedge clock);
    #1;
    reset = 1'b1;
    m_pc = RPC;
    run(3);

    // Streaming from 0x00 with one-cycle memory latency.
    drive(1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
    step();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    run(12);

    // Backpressure: credit allows exactly DEPTH requests.
    drain();
    n_acc = 0;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    run(10);
    chk("bp_accepts", n_acc, DEPTH);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    run(4);

    // Squash two in-flight requests with a redirect to 0x40.
    drain();
    resp_mode = 0;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    run(2);
    drive(1'b1, 1'b1, 8'h40, 1'b1, 1'b1);
    step();
    resp_mode = 1;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    run(8);

    // PC wrap and enable stall.
    drive(1'b1, 1'b1, 8'hFE, 1'b1, 1'b1);
    step();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    run(4);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    run(3);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    run(3);

    // Random traffic, including redirects landing on responses.
    resp_mode = 2;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      step();
    end

    // Asynchronous reset with three entries queued.
    drain();
    resp_mode = 1;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    run(4);
    chk("pre_rst_out_valid", out_valid, 1'b1);
    #3;
    reset = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_pc", PC, RPC);
    chk("async_rst_req_valid", imem_req_valid, 1'b0);
    outst.delete();
    outq.delete();
    m_pc = RPC;
    @(posedge clock);
    #1;
    reset = 1'b1;
    resp_mode = 2;
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
